ahb_obi_master: RTL and testbench

AHB initiator port that converts a core-side OBI-style request/grant/valid interface (as used by the cv32e40p instruction and data ports) into AHB master-port signals on one `ahb_bus` master slot. It handles bus arbitration (HBUSREQ/HGRANT), drives pipelined address/data phases with at most one data phase outstanding, and returns read data and completion to the core. It sits between `cv32e40p_top` and the `ahb_bus` master inputs, and replaces hand-driven HADDR_Mx/HWRITE_Mx/HWDATA_Mx stimulus.

---
 rtl/ahb_pkg.sv | 18 +
 rtl/ahb_obi_master.sv | 146 ++++++++++++++
 tb/tb_ahb_obi_master.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer-type encoding and master-port FSM states.
// Imported by every AHB block in the subsystem.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      MST_IDLE = 2'b00,
      MST_ARB  = 2'b01,
      MST_OWN  = 2'b10
   } ahb_mst_state_t;

endpackage

// File: rtl/ahb_obi_master.sv
// OBI-style req/gnt/rvalid core port to AHB master port bridge: arbitration,
// pipelined address/data phases with at most one data phase outstanding.
module ahb_obi_master
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]           wdata_i,
   output logic                  gnt_o,
   output logic                  rvalid_o,
   output logic [31:0]           rdata_o,
   output logic                  HBUSREQ,
   output logic                  HLOCK,
   input  logic                  HGRANT,
   output logic [ADDR_WIDTH-1:0] HADDR,
   output logic [1:0]            HTRANS,
   output logic                  HWRITE,
   output logic [31:0]           HWDATA,
   input  logic [31:0]           HRDATA,
   input  logic                  HREADY
);

   ahb_mst_state_t r_state;
   logic           r_own;
   logic           r_dphase_valid;
   logic           r_dphase_we;
   logic [31:0]    r_hwdata;

   logic           w_own_d;
   logic           w_aphase;
   logic           w_gnt;
   logic           w_rvalid;

   // Ownership only changes on a completed bus cycle.
   assign w_own_d  = HREADY ? HGRANT : r_own;
   // A parked grant lets an address phase start straight from IDLE.
   assign w_aphase = r_own & req_i & (r_state != MST_ARB);
   assign w_gnt    = w_aphase & HREADY;
   assign w_rvalid = r_dphase_valid & HREADY;

   // Ownership bit tracking the arbiter grant.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_own <= 1'b0;
      end else begin
         r_own <= w_own_d;
      end
   end

   // Bus-request FSM.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state <= MST_IDLE;
      end else begin
         case (r_state)
            MST_IDLE: begin
               if (req_i) begin
                  r_state <= w_own_d ? MST_OWN : MST_ARB;
               end else begin
                  r_state <= MST_IDLE;
               end
            end
            MST_ARB: begin
               if (w_own_d) begin
                  r_state <= MST_OWN;
               end else begin
                  r_state <= MST_ARB;
               end
            end
            MST_OWN: begin
               if (!w_own_d) begin
                  r_state <= req_i ? MST_ARB : MST_IDLE;
               end else if (!req_i && !r_dphase_valid) begin
                  r_state <= MST_IDLE;
               end else begin
                  r_state <= MST_OWN;
               end
            end
            default: r_state <= MST_IDLE;
         endcase
      end
   end

   // Data-phase tracking and registered write data.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_dphase_valid <= 1'b0;
         r_dphase_we    <= 1'b0;
         r_hwdata       <= 32'h0000_0000;
      end else begin
         if (w_gnt) begin
            r_dphase_valid <= 1'b1;
            r_dphase_we    <= we_i;
            if (we_i) begin
               r_hwdata <= wdata_i;
            end else begin
               r_hwdata <= r_hwdata;
            end
         end else if (w_rvalid) begin
            r_dphase_valid <= 1'b0;
            r_dphase_we    <= r_dphase_we;
            r_hwdata       <= r_hwdata;
         end else begin
            r_dphase_valid <= r_dphase_valid;
            r_dphase_we    <= r_dphase_we;
            r_hwdata       <= r_hwdata;
         end
      end
   end

   // Address-phase, request and completion outputs.
   always_comb begin
      HLOCK    = 1'b0;
      HWDATA   = r_hwdata;
      gnt_o    = w_gnt;
      rvalid_o = w_rvalid;
      HTRANS   = HTRANS_IDLE;
      HADDR    = {ADDR_WIDTH{1'b0}};
      HWRITE   = 1'b0;
      rdata_o  = 32'h0000_0000;
      if (w_aphase) begin
         HTRANS = HTRANS_NONSEQ;
         HADDR  = addr_i;
         HWRITE = we_i;
      end else begin
         HTRANS = HTRANS_IDLE;
      end
      if (w_rvalid && !r_dphase_we) begin
         rdata_o = HRDATA;
      end else begin
         rdata_o = 32'h0000_0000;
      end
      case (r_state)
         MST_IDLE: HBUSREQ = 1'b0;
         MST_ARB:  HBUSREQ = 1'b1;
         MST_OWN:  HBUSREQ = req_i | r_dphase_valid;
         default:  HBUSREQ = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_ahb_obi_master.sv
// Directed self-checking bench for ahb_obi_master.
module tb_ahb_obi_master;
   logic        HCLK;
   logic        HRESETn;
   logic        req_i;
   logic        we_i;
   logic [15:0] addr_i;
   logic [31:0] wdata_i;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        HBUSREQ;
   logic        HLOCK;
   logic        HGRANT;
   logic [15:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;

   int n_tests;
   int n_fail;
   logic [31:0] rnd;

   ahb_obi_master #(.ADDR_WIDTH(16)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
      .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HGRANT(HGRANT),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge HCLK);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busreq"}, {31'd0, HBUSREQ}, 32'd0);
      check_eq({tag, "_hlock"},  {31'd0, HLOCK},   32'd0);
      check_eq({tag, "_htrans"}, {30'd0, HTRANS},  32'd0);
      check_eq({tag, "_haddr"},  {16'd0, HADDR},   32'd0);
      check_eq({tag, "_hwrite"}, {31'd0, HWRITE},  32'd0);
      check_eq({tag, "_hwdata"}, HWDATA,           32'd0);
      check_eq({tag, "_gnt"},    {31'd0, gnt_o},   32'd0);
      check_eq({tag, "_rvalid"}, {31'd0, rvalid_o}, 32'd0);
      check_eq({tag, "_rdata"},  rdata_o,          32'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      HRESETn = 1'b0;
      req_i = 1'b0; we_i = 1'b0; addr_i = 16'h0000; wdata_i = 32'h0;
      HGRANT = 1'b0; HREADY = 1'b1; HRDATA = 32'h0;

      // Reset held with random inputs.
      for (int i = 0; i < 4; i++) begin
         next_cyc();
         rnd = $urandom;
         req_i = rnd[0]; we_i = rnd[1]; HGRANT = rnd[2]; HREADY = rnd[3];
         addr_i = rnd[31:16];
         wdata_i = $urandom;
         HRDATA  = $urandom;
         #1;
         check_all_zero("rst");
      end
      req_i = 1'b0; we_i = 1'b0; addr_i = 16'h0000; wdata_i = 32'h0;
      HGRANT = 1'b0; HREADY = 1'b1; HRDATA = 32'h0;
      #1 HRESETn = 1'b1;

      // Single write, grant arriving two cycles after the request.
      next_cyc();
      req_i = 1'b1; we_i = 1'b1; addr_i = 16'hd000; wdata_i = 32'h0000_1000;
      #1;
      check_eq("wr_busreq_first", {31'd0, HBUSREQ}, 32'd0);
      check_eq("wr_gnt_first", {31'd0, gnt_o}, 32'd0);
      next_cyc(); #1;
      check_eq("wr_busreq_arb", {31'd0, HBUSREQ}, 32'd1);
      check_eq("wr_htrans_arb", {30'd0, HTRANS}, 32'd0);
      next_cyc(); HGRANT = 1'b1; #1;
      check_eq("wr_busreq_arb2", {31'd0, HBUSREQ}, 32'd1);
      check_eq("wr_gnt_arb2", {31'd0, gnt_o}, 32'd0);
      next_cyc(); #1;
      check_eq("wr_htrans_ns", {30'd0, HTRANS}, 32'd2);
      check_eq("wr_haddr", {16'd0, HADDR}, 32'h0000_d000);
      check_eq("wr_hwrite", {31'd0, HWRITE}, 32'd1);
      check_eq("wr_gnt", {31'd0, gnt_o}, 32'd1);
      next_cyc(); req_i = 1'b0; we_i = 1'b0; addr_i = 16'h0000; #1;
      check_eq("wr_hwdata", HWDATA, 32'h0000_1000);
      check_eq("wr_rvalid", {31'd0, rvalid_o}, 32'd1);
      check_eq("wr_rdata_zero", rdata_o, 32'd0);
      check_eq("wr_gnt_after", {31'd0, gnt_o}, 32'd0);
      check_eq("wr_htrans_after", {30'd0, HTRANS}, 32'd0);
      check_eq("wr_busreq_dph", {31'd0, HBUSREQ}, 32'd1);
      next_cyc(); #1;
      check_eq("wr_rvalid_done", {31'd0, rvalid_o}, 32'd0);
      check_eq("wr_busreq_done", {31'd0, HBUSREQ}, 32'd0);

      // Read with two wait states in the data phase (parked grant).
      next_cyc();
      req_i = 1'b1; we_i = 1'b0; addr_i = 16'h0010; HRDATA = 32'hDEAD_BEEF; #1;
      check_eq("rd_gnt", {31'd0, gnt_o}, 32'd1);
      check_eq("rd_htrans", {30'd0, HTRANS}, 32'd2);
      check_eq("rd_hwrite", {31'd0, HWRITE}, 32'd0);
      next_cyc(); req_i = 1'b0; HREADY = 1'b0; #1;
      check_eq("rd_wait1_rvalid", {31'd0, rvalid_o}, 32'd0);
      check_eq("rd_wait1_rdata", rdata_o, 32'd0);
      check_eq("rd_hwdata_hold", HWDATA, 32'h0000_1000);
      next_cyc(); #1;
      check_eq("rd_wait2_rvalid", {31'd0, rvalid_o}, 32'd0);
      next_cyc(); HREADY = 1'b1; #1;
      check_eq("rd_rvalid", {31'd0, rvalid_o}, 32'd1);
      check_eq("rd_rdata", rdata_o, 32'hDEAD_BEEF);
      next_cyc(); #1;
      check_eq("rd_rvalid_done", {31'd0, rvalid_o}, 32'd0);
      check_eq("rd_rdata_done", rdata_o, 32'd0);

      // Back-to-back reads.
      next_cyc();
      req_i = 1'b1; we_i = 1'b0; addr_i = 16'h0000; HRDATA = 32'h1111_1111; #1;
      check_eq("b2b_gnt0", {31'd0, gnt_o}, 32'd1);
      check_eq("b2b_rvalid0", {31'd0, rvalid_o}, 32'd0);
      next_cyc(); addr_i = 16'h0004; HRDATA = 32'h2222_2222; #1;
      check_eq("b2b_gnt1", {31'd0, gnt_o}, 32'd1);
      check_eq("b2b_haddr1", {16'd0, HADDR}, 32'h0000_0004);
      check_eq("b2b_rvalid1", {31'd0, rvalid_o}, 32'd1);
      check_eq("b2b_rdata1", rdata_o, 32'h2222_2222);
      next_cyc(); req_i = 1'b0; addr_i = 16'h0000; HRDATA = 32'h3333_3333; #1;
      check_eq("b2b_gnt2", {31'd0, gnt_o}, 32'd0);
      check_eq("b2b_rvalid2", {31'd0, rvalid_o}, 32'd1);
      check_eq("b2b_rdata2", rdata_o, 32'h3333_3333);
      next_cyc(); #1;
      check_eq("b2b_rvalid3", {31'd0, rvalid_o}, 32'd0);

      // Grant removed during the first address phase, request kept high.
      next_cyc();
      req_i = 1'b1; we_i = 1'b1; addr_i = 16'h0020; wdata_i = 32'hABCD_0001; HGRANT = 1'b0; #1;
      check_eq("lost_gnt", {31'd0, gnt_o}, 32'd1);
      next_cyc(); we_i = 1'b0; addr_i = 16'h0024; #1;
      check_eq("lost_rvalid", {31'd0, rvalid_o}, 32'd1);
      check_eq("lost_htrans", {30'd0, HTRANS}, 32'd0);
      check_eq("lost_gnt2", {31'd0, gnt_o}, 32'd0);
      check_eq("lost_busreq", {31'd0, HBUSREQ}, 32'd1);
      check_eq("lost_hwdata", HWDATA, 32'hABCD_0001);
      next_cyc(); HGRANT = 1'b1; #1;
      check_eq("lost_arb_htrans", {30'd0, HTRANS}, 32'd0);
      check_eq("lost_arb_rvalid", {31'd0, rvalid_o}, 32'd0);
      check_eq("lost_arb_busreq", {31'd0, HBUSREQ}, 32'd1);
      next_cyc(); #1;
      check_eq("regrant_gnt", {31'd0, gnt_o}, 32'd1);
      check_eq("regrant_haddr", {16'd0, HADDR}, 32'h0000_0024);

      // Reset dropped while a data phase is in flight.
      next_cyc(); req_i = 1'b0; HRDATA = 32'h5555_AAAA; #1;
      check_eq("pre_rst_rvalid", {31'd0, rvalid_o}, 32'd1);
      HRESETn = 1'b0; #1;
      check_all_zero("midrst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
